// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RV32I-subset core:
// ALU ops, immediate formats, opcodes, mux selects and controller states.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_BPASS = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_ADDI = 3'd0,
        IMM_SLLI = 3'd1,
        IMM_SW   = 3'd2,
        IMM_LUI  = 3'd3,
        IMM_B    = 3'd4,
        IMM_J    = 3'd5
    } sign_extend_t;

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111,
        OP_BRANCH = 7'b1100011
    } OPCODE_TYPE;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MDR    = 2'd1,
        RES_ALU    = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_REG   = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_EXEC_LUI  = 4'd8,
        S_JAL       = 4'd9,
        S_ALU_WB    = 4'd10,
        S_BEQ       = 4'd11,
        S_ILLEGAL   = 4'd12
    } ctrl_state_t;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_BEQ  = 3'b000;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for R-type and I-type ALU instructions.
// Flags funct7 encodings outside the base/alternate pair as illegal.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic f7_alt;
    logic f7_ok;

    assign f7_alt = (funct7 == F7_ALT);
    assign f7_ok  = (funct7 == F7_BASE) || f7_alt;

    // I-type only carries funct7 meaning for the shift-right pair
    assign illegal = is_rtype ? !f7_ok
                              : (funct3 == 3'b101) && !f7_ok;

    always_comb begin
        alu_op = ALU_ADD;
        unique case (funct3)
            3'b000: alu_op = (is_rtype && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLT;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the multicycle datapath over a shared
// req/ready memory; halts on illegal encodings and counts retirements.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int RETIRED_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_op,
    output logic [2:0]           imm_src,
    output logic                 halted,
    output logic [RETIRED_W-1:0] retired
);

    ctrl_state_t          state;
    ctrl_state_t          next_state;
    logic [RETIRED_W-1:0] count;
    logic                 retire;
    logic [3:0]           dec_op;
    logic                 dec_illegal;

    logic is_rtype;
    logic is_itype;
    logic is_mem;
    logic is_lui;
    logic is_jal;
    logic is_beq;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_itype = (opcode == OP_ITYPE);
    assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_lui   = (opcode == OP_LUI);
    assign is_jal   = (opcode == OP_JAL);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);

    alu_decoder u_alu_decoder (
        .is_rtype (is_rtype),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op   (dec_op),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                count <= count + RETIRED_W'(1);
        end
    end

    assign retired = reset ? '0 : count;

    // Reset gates every strobe in the same cycle it is sampled
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        imm_src    = IMM_ADDI;
        halted     = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready)
                        next_state = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    unique case (1'b1)
                        is_mem:   next_state = S_MEM_ADR;
                        is_rtype: next_state = dec_illegal ? S_ILLEGAL
                                                           : S_EXEC_R;
                        is_itype: next_state = dec_illegal ? S_ILLEGAL
                                                           : S_EXEC_I;
                        is_lui:   next_state = S_EXEC_LUI;
                        is_jal:   next_state = S_JAL;
                        is_beq:   next_state = S_BEQ;
                        default:  next_state = S_ILLEGAL;
                    endcase
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_STORE) begin
                        imm_src    = IMM_SW;
                        next_state = S_MEM_WRITE;
                    end else begin
                        next_state = S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready)
                        next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    result_src = RES_MDR;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready)
                        next_state = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a  = SRCA_REG;
                    alu_op     = dec_op;
                    next_state = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    alu_op    = dec_op;
                    if (funct3 == 3'b001 || funct3 == 3'b101)
                        imm_src = IMM_SLLI;
                    next_state = S_ALU_WB;
                end
                S_EXEC_LUI: begin
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_LUI;
                    alu_op     = ALU_BPASS;
                    next_state = S_ALU_WB;
                end
                S_JAL: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    pc_write   = 1'b1;
                    next_state = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a  = SRCA_REG;
                    alu_op     = ALU_SUB;
                    pc_write   = zero;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_ILLEGAL: begin
                    halted = 1'b1;
                end
                default: begin
                    next_state = S_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, corner-case
// sequences and randomized instruction stream against a cycle-count model.
module tb_multicycle_controller;

    localparam int RW = 4;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0040A103;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4050D093;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write;
    logic          pc_write, reg_write, halted;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [3:0]    alu_op;
    logic [2:0]    imm_src;
    logic [RW-1:0] retired;

    multicycle_controller #(.RETIRED_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       wr;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] op;
        logic [2:0] imm;
        logic       h;
    } ctl_t;

    typedef struct {
        bit          rst;
        logic [31:0] ins;
        bit          z;
        bit          rdy;
        ctl_t        exp;
        int          ret;
    } vec_t;

    ctl_t got;
    assign got = {mem_req, mem_write, adr_src, ir_write, pc_write,
                  reg_write, result_src, alu_src_a, alu_src_b,
                  alu_op, imm_src, halted};

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic ctl_t C(int req, int wr, int adr, int irw,
                               int pcw, int rw, int res, int a,
                               int b, int op, int imm, int h);
        ctl_t c;
        c.req = req[0];
        c.wr  = wr[0];
        c.adr = adr[0];
        c.irw = irw[0];
        c.pcw = pcw[0];
        c.rw  = rw[0];
        c.res = res[1:0];
        c.a   = a[1:0];
        c.b   = b[1:0];
        c.op  = op[3:0];
        c.imm = imm[2:0];
        c.h   = h[0];
        return c;
    endfunction

    function automatic ctl_t c_fetch();
        return C(1, 0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0);
    endfunction

    function automatic ctl_t c_decode();
        return C(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
    endfunction

    function automatic ctl_t c_wb();
        return C(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    // Spec mapping of funct3/funct7 to ALU operation codes
    function automatic int ref_aluop(bit is_r, logic [2:0] f3,
                                     logic [6:0] f7);
        case (f3)
            3'd0:    return (is_r && f7 == 7'h20) ? 1 : 0;
            3'd1:    return 5;
            3'd2:    return 8;
            3'd3:    return 8;
            3'd4:    return 4;
            3'd5:    return (f7 == 7'h20) ? 7 : 6;
            3'd6:    return 3;
            default: return 2;
        endcase
    endfunction

    task automatic add(bit r, logic [31:0] ins, bit z, bit rdy,
                       ctl_t e, int ret);
        vec_t v;
        v.rst = r;
        v.ins = ins;
        v.z   = z;
        v.rdy = rdy;
        v.exp = e;
        v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic chk(string n, int g, int e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, g, e);
        end
    endtask

    task automatic cyc(bit r, logic [31:0] ins, bit z, bit rdy);
        @(negedge clk);
        reset     = r;
        opcode    = ins[6:0];
        funct3    = ins[14:12];
        funct7    = ins[31:25];
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        cyc(1, I_ADDI, 0, 1);
        chk("reset_outputs", int'(got), 0);
    endtask

    task automatic run_addi();
        for (int i = 0; i < 4; i++)
            cyc(0, I_ADDI, 0, 1);
    endtask

    task automatic illegal_seq(string n, logic [31:0] bad);
        do_reset();
        run_addi();
        cyc(0, bad, 0, 1);
        chk({n, "_fetch"}, int'(got), int'(c_fetch()));
        cyc(0, bad, 0, 1);
        chk({n, "_decode_nohalt"}, int'(halted), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, bad, i[0], $urandom_range(0, 1) != 0);
            chk({n, "_halted"}, int'(got),
                int'(C(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
            chk({n, "_retired"}, int'(retired), 1);
        end
        cyc(1, bad, 0, 1);
        chk({n, "_reset_gate"}, int'(got), 0);
        cyc(0, I_ADDI, 0, 1);
        chk({n, "_after_reset"}, int'(got), int'(c_fetch()));
        chk({n, "_after_retired"}, int'(retired), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Cycle-by-cycle vectors with zero-wait memory
        add(1, I_ADDI, 0, 1, '0, 0);
        add(0, I_ADDI, 0, 1, c_fetch(), 0);
        add(0, I_ADDI, 0, 1, c_decode(), 0);
        add(0, I_ADDI, 0, 1, C(0,0,0,0,0,0,0,2,1,0,0,0), 0);
        add(0, I_ADDI, 0, 1, c_wb(), 0);
        add(0, I_LW, 0, 1, c_fetch(), 1);
        add(0, I_LW, 0, 1, c_decode(), 1);
        add(0, I_LW, 0, 1, C(0,0,0,0,0,0,0,2,1,0,0,0), 1);
        add(0, I_LW, 0, 1, C(1,0,1,0,0,0,0,0,0,0,0,0), 1);
        add(0, I_LW, 0, 1, C(0,0,0,0,0,1,1,0,0,0,0,0), 1);
        add(0, I_SW, 0, 1, c_fetch(), 2);
        add(0, I_SW, 0, 1, c_decode(), 2);
        add(0, I_SW, 0, 1, C(0,0,0,0,0,0,0,2,1,0,2,0), 2);
        add(0, I_SW, 0, 1, C(1,1,1,0,0,0,0,0,0,0,0,0), 2);
        add(0, I_BEQ, 1, 1, c_fetch(), 3);
        add(0, I_BEQ, 1, 1, c_decode(), 3);
        add(0, I_BEQ, 1, 1, C(0,0,0,0,1,0,0,2,0,1,0,0), 3);
        add(0, I_BEQ, 0, 1, c_fetch(), 4);
        add(0, I_BEQ, 0, 1, c_decode(), 4);
        add(0, I_BEQ, 0, 1, C(0,0,0,0,0,0,0,2,0,1,0,0), 4);
        add(0, I_JAL, 0, 1, c_fetch(), 5);
        add(0, I_JAL, 0, 1, c_decode(), 5);
        add(0, I_JAL, 0, 1, C(0,0,0,0,1,0,0,1,2,0,0,0), 5);
        add(0, I_JAL, 0, 1, c_wb(), 5);
        add(0, I_SUB, 0, 1, c_fetch(), 6);
        add(0, I_SUB, 0, 1, c_decode(), 6);
        add(0, I_SUB, 0, 1, C(0,0,0,0,0,0,0,2,0,1,0,0), 6);
        add(0, I_SUB, 0, 1, c_wb(), 6);
        add(0, I_SRAI, 0, 1, c_fetch(), 7);
        add(0, I_SRAI, 0, 1, c_decode(), 7);
        add(0, I_SRAI, 0, 1, C(0,0,0,0,0,0,0,2,1,7,1,0), 7);
        add(0, I_SRAI, 0, 1, c_wb(), 7);
        add(0, I_LUI, 0, 1, c_fetch(), 8);
        add(0, I_LUI, 0, 1, c_decode(), 8);
        add(0, I_LUI, 0, 1, C(0,0,0,0,0,0,0,0,1,9,3,0), 8);
        add(0, I_LUI, 0, 1, c_wb(), 8);
        add(0, I_ADDI, 0, 1, c_fetch(), 9);

        cyc(1, I_ADDI, 0, 1);
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].ins, vecs[i].z, vecs[i].rdy);
            chk($sformatf("vec%0d_ctl", i), int'(got),
                int'(vecs[i].exp));
            chk($sformatf("vec%0d_retired", i), int'(retired),
                vecs[i].ret);
        end

        // Fetch stalls until mem_ready
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, I_ADDI, 0, 0);
            chk("fetch_wait", int'({mem_req, ir_write, pc_write}), 4);
        end
        cyc(0, I_ADDI, 0, 1);
        chk("fetch_done", int'({mem_req, ir_write, pc_write}), 7);
        cyc(0, I_ADDI, 0, 0);
        chk("fetch_to_decode", int'(got), int'(c_decode()));

        illegal_seq("illegal_op", I_BAD);
        illegal_seq("illegal_f7", I_MUL);

        // Reset dominates an in-flight store
        do_reset();
        run_addi();
        cyc(0, I_SW, 0, 1);
        cyc(0, I_SW, 0, 1);
        cyc(0, I_SW, 0, 1);
        cyc(0, I_SW, 0, 0);
        chk("sw_wait", int'({mem_req, mem_write, adr_src}), 7);
        cyc(1, I_SW, 0, 0);
        chk("sw_reset_gate", int'(got), 0);
        cyc(0, I_SW, 0, 1);
        chk("sw_reset_fetch", int'(got), int'(c_fetch()));
        chk("sw_reset_retired", int'(retired), 0);

        // Randomized stream with memory wait states
        do_reset();
        begin
            int exp_ret;
            exp_ret = 0;
            for (int n = 0; n < 300; n++) begin
                int          kind, base, waits, cn;
                int          rwc, pcc, irc, mwc, aseen, abad, eop;
                bit          z;
                logic [31:0] ins;
                ins   = $urandom;
                kind  = $urandom_range(0, 6);
                z     = $urandom_range(0, 1) != 0;
                base  = 4;
                waits = 0;
                cn    = 0;
                rwc   = 0;
                pcc   = 0;
                irc   = 0;
                mwc   = 0;
                aseen = 0;
                abad  = 0;
                case (kind)
                    0: begin
                        ins[6:0]   = 7'b0110011;
                        ins[31:25] = ins[25] ? 7'h20 : 7'h00;
                    end
                    1: begin
                        ins[6:0] = 7'b0010011;
                        if (ins[14:12] == 3'd5)
                            ins[31:25] = ins[25] ? 7'h20 : 7'h00;
                    end
                    2: ins[6:0] = 7'b0110111;
                    3: begin
                        ins[6:0] = 7'b0000011;
                        base     = 5;
                    end
                    4: ins[6:0] = 7'b0100011;
                    5: ins[6:0] = 7'b1101111;
                    default: begin
                        ins[6:0]   = 7'b1100011;
                        ins[14:12] = 3'd0;
                        base       = 3;
                    end
                endcase
                eop = ref_aluop(kind == 0, ins[14:12], ins[31:25]);
                while (cn < base + waits && cn < 64) begin
                    cyc(0, ins, z, $urandom_range(0, 3) != 0);
                    if (cn == 0) begin
                        chk("rnd_fetch",
                            int'({mem_req, adr_src, alu_src_b}), 10);
                        chk("rnd_retired", int'(retired), exp_ret);
                    end
                    if (mem_req && !mem_ready)
                        waits++;
                    rwc += int'(reg_write);
                    pcc += int'(pc_write);
                    irc += int'(ir_write);
                    mwc += int'(mem_write && mem_ready);
                    if (alu_src_a == 2'd2) begin
                        aseen++;
                        if (int'(alu_op) != eop)
                            abad++;
                    end
                    cn++;
                end
                chk("rnd_ir_write", irc, 1);
                chk("rnd_reg_write", rwc,
                    (kind == 4 || kind == 6) ? 0 : 1);
                chk("rnd_pc_write", pcc,
                    1 + int'(kind == 5) + int'(kind == 6 && z));
                chk("rnd_store", mwc, int'(kind == 4));
                chk("rnd_halted", int'(halted), 0);
                if (kind <= 1)
                    chk("rnd_aluop", abad * 100 + aseen, 1);
                exp_ret = (exp_ret + 1) % (1 << RW);
            end
            cyc(0, I_ADDI, 0, 1);
            chk("rnd_final_fetch",
                int'({mem_req, adr_src, alu_src_b}), 10);
            chk("rnd_final_retired", int'(retired), exp_ret);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
